uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a small show-ahead FIFO.
//
// Ports:
//   CLOCK       single clock, rising edge
//   RESET       synchronous active-high reset
//   dvsr        clocks per baud tick (0 or 1 disables reception)
//   serial_in   asynchronous UART line, idle high
//   rd_en       pop the FIFO head
//   clr_err     clear the sticky error flags
//   rd_data     FIFO head (show-ahead), zero while empty
//   empty/full  FIFO status
//   count       entries held
//   frame_err   sticky: a stop bit was sampled low
//   parity_err  sticky: a frame failed its parity check
//   overrun     sticky: a good frame was dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DVSR_W     = 11
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic [DVSR_W-1:0]        dvsr,
    input  logic                     serial_in,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     overrun
);

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LST = BIT_W'(STOP_BITS - 1);
    localparam logic             HAS_PAR  = (PARITY_EN != 0);
    localparam logic             ODD_PAR  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic rx;

    assign rx = sync2_q;

    // ------------------------------------------------------------------
    // Baud tick generator
    // ------------------------------------------------------------------
    logic [DVSR_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              baud_ok;
    logic              tick;

    assign baud_ok = (dvsr > DVSR_W'(1));
    // >= rather than == so a shrinking dvsr mid-count restarts cleanly.
    assign tick    = baud_ok && (tick_cnt_q >= dvsr - DVSR_W'(1));

    always_comb begin
        tick_cnt_d = tick_cnt_q + DVSR_W'(1);
        if (!baud_ok || tick) begin
            tick_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frm_bad_q, frm_bad_d;
    logic                 frame_done;
    logic                 frm_bad_fin;
    logic                 push_req;
    logic                 exp_par;

    assign exp_par = (^shift_q) ^ ODD_PAR;

    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        frm_bad_d  = frm_bad_q;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (baud_ok && !rx) begin
                    state_d   = StStart;
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                    frm_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (os_cnt_q == OS_MID) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        // Line back high at mid-start: treat as a glitch.
                        state_d   = rx ? StIdle : StData;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        shift_d  = {rx, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == DATA_LST) begin
                            bit_cnt_d = '0;
                            state_d   = HAS_PAR ? StParity : StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        par_bad_d = (rx != exp_par);
                        state_d   = StStop;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        if (!rx) begin
                            frm_bad_d = 1'b1;
                        end
                        if (bit_cnt_q == STOP_LST) begin
                            bit_cnt_d  = '0;
                            frame_done = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Include the current stop sample, which has not reached frm_bad_q yet.
    assign frm_bad_fin = frm_bad_q | !rx;
    assign push_req    = frame_done && !frm_bad_fin && !par_bad_q;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_req && (!full || rd_en);
    assign do_pop  = rd_en && !empty;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (do_push && !RESET) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags (a same-cycle set beats clr_err)
    // ------------------------------------------------------------------
    logic frame_err_q, frame_err_d;
    logic parity_err_q, parity_err_d;
    logic overrun_q, overrun_d;

    always_comb begin
        frame_err_d  = (frame_done && frm_bad_fin) | (frame_err_q  & ~clr_err);
        parity_err_d = (frame_done && par_bad_q)   | (parity_err_q & ~clr_err);
        overrun_d    = (push_req && full && !rd_en) | (overrun_q   & ~clr_err);
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            tick_cnt_q   <= '0;
            state_q      <= StIdle;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frm_bad_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= serial_in;
            sync2_q      <= sync1_q;
            tick_cnt_q   <= tick_cnt_d;
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frm_bad_q    <= frm_bad_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default instance (a) and an even-parity instance (b).
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [10:0] dvsr;
    logic        serial_a, serial_b;
    logic        rd_a, rd_b, clr_a, clr_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic        empty_a, full_a, empty_b, full_b;
    logic [2:0]  count_a, count_b;
    logic        ferr_a, perr_a, ovr_a, ferr_b, perr_b, ovr_b;

    int          checks = 0;
    int          errors = 0;
    int          bit_clks;
    logic [7:0]  sb[$];

    always #5 CLOCK = ~CLOCK;

    uart_rx_fifo u_a (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .dvsr       (dvsr),
        .serial_in  (serial_a),
        .rd_en      (rd_a),
        .clr_err    (clr_a),
        .rd_data    (rd_data_a),
        .empty      (empty_a),
        .full       (full_a),
        .count      (count_a),
        .frame_err  (ferr_a),
        .parity_err (perr_a),
        .overrun    (ovr_a)
    );

    uart_rx_fifo #(
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) u_b (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .dvsr       (dvsr),
        .serial_in  (serial_b),
        .rd_en      (rd_b),
        .clr_err    (clr_b),
        .rd_data    (rd_data_b),
        .empty      (empty_b),
        .full       (full_b),
        .count      (count_b),
        .frame_err  (ferr_b),
        .parity_err (perr_b),
        .overrun    (ovr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) serial_b = v;
        else     serial_a = v;
    endtask

    // Start, 8 data bits LSB first, optional parity, one stop bit, 2 idle bits.
    // A bad stop is held low just past the receiver's mid-bit sample point.
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit has_par,
                              input logic par, input bit stop_ok);
        set_line(sel, 1'b0);
        wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, data[i]);
            wait_clks(bit_clks);
        end
        if (has_par) begin
            set_line(sel, par);
            wait_clks(bit_clks);
        end
        if (stop_ok) begin
            set_line(sel, 1'b1);
            wait_clks(bit_clks);
        end else begin
            set_line(sel, 1'b0);
            wait_clks(bit_clks / 2 + int'(dvsr) + 40);
            set_line(sel, 1'b1);
            wait_clks(bit_clks / 2);
        end
        set_line(sel, 1'b1);
        wait_clks(2 * bit_clks);
    endtask

    task automatic send_a(input logic [7:0] data);
        sb.push_back(data);
        send_frame(1'b0, data, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pulse_rd_a();
        rd_a = 1'b1;
        @(negedge CLOCK);
        rd_a = 1'b0;
    endtask

    task automatic drain_a(input string tag);
        logic [7:0] exp;
        check({tag, "_count"}, 32'(count_a), 32'(sb.size()));
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, "_rd_data"}, 32'(rd_data_a), 32'(exp));
            pulse_rd_a();
        end
        check({tag, "_empty"}, 32'(empty_a), 32'd1);
    endtask

    initial begin : stim
        bit found;
        RESET    = 1'b1;
        dvsr     = 11'd26;
        bit_clks = 26 * 16;
        serial_a = 1'b1;
        serial_b = 1'b1;
        rd_a     = 1'b0;
        rd_b     = 1'b0;
        clr_a    = 1'b0;
        clr_b    = 1'b0;
        wait_clks(3);

        // Reset values
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_empty", 32'(empty_a), 32'd1);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_rd_data", 32'(rd_data_a), 32'd0);
        check("rst_flags", {29'd0, ferr_a, perr_a, ovr_a}, 32'd0);
        RESET = 1'b0;
        wait_clks(5);

        // Three bytes, no reads, then drain
        send_a(8'h05);
        send_a(8'h0A);
        send_a(8'h0C);
        check("three_count", 32'(count_a), 32'd3);
        check("three_head", 32'(rd_data_a), 32'h05);
        drain_a("three");

        // Pop while empty is ignored
        pulse_rd_a();
        check("empty_pop_count", 32'(count_a), 32'd0);
        check("empty_pop_empty", 32'(empty_a), 32'd1);

        // Low stop bit
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        check("ferr_set", 32'(ferr_a), 32'd1);
        check("ferr_count", 32'(count_a), 32'd0);
        check("ferr_no_perr", 32'(perr_a), 32'd0);
        clr_a = 1'b1;
        @(negedge CLOCK);
        clr_a = 1'b0;
        check("ferr_clr", 32'(ferr_a), 32'd0);

        // 100-clock start glitch
        serial_a = 1'b0;
        wait_clks(100);
        serial_a = 1'b1;
        wait_clks(800);
        check("glitch_count", 32'(count_a), 32'd0);
        check("glitch_flags", {29'd0, ferr_a, perr_a, ovr_a}, 32'd0);
        send_a(8'h3C);
        drain_a("post_glitch");

        // dvsr = 0 and 1 produce no reception
        bit_clks = 64;
        dvsr     = 11'd0;
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        check("dvsr0_count", 32'(count_a), 32'd0);
        dvsr = 11'd1;
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("dvsr1_count", 32'(count_a), 32'd0);
        check("dvsr1_flags", {29'd0, ferr_a, perr_a, ovr_a}, 32'd0);
        dvsr = 11'd4;
        wait_clks(100);

        // Five bytes into a 4-deep FIFO: overrun, fifth dropped
        for (int i = 1; i <= 4; i++) send_a(8'(i));
        send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
        check("ovr_full", 32'(full_a), 32'd1);
        check("ovr_set", 32'(ovr_a), 32'd1);
        drain_a("ovr");
        clr_a = 1'b1;
        @(negedge CLOCK);
        clr_a = 1'b0;
        check("ovr_clr", 32'(ovr_a), 32'd0);

        // Same again with a pop on the fifth push cycle
        for (int i = 1; i <= 4; i++) send_a(8'(i));
        found = 1'b0;
        fork
            send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge CLOCK);
                    if (u_a.push_req) begin
                        check("fullpop_head", 32'(rd_data_a), 32'(sb.pop_front()));
                        rd_a = 1'b1;
                        @(negedge CLOCK);
                        rd_a  = 1'b0;
                        found = 1'b1;
                        sb.push_back(8'h05);
                        break;
                    end
                end
            end
        join
        check("fullpop_seen", 32'(found), 32'd1);
        check("fullpop_no_ovr", 32'(ovr_a), 32'd0);
        check("fullpop_count", 32'(count_a), 32'd4);
        check("fullpop_head2", 32'(rd_data_a), 32'h02);

        // Reset in the middle of data bit 3 of 0xA5 (FIFO still full)
        serial_a = 1'b0;
        wait_clks(bit_clks);
        for (int i = 0; i < 3; i++) begin
            serial_a = (8'hA5 >> i) & 8'h01;
            wait_clks(bit_clks);
        end
        serial_a = 1'b0;
        wait_clks(bit_clks / 2);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET    = 1'b0;
        serial_a = 1'b1;
        sb.delete();
        check("midrst_count", 32'(count_a), 32'd0);
        check("midrst_empty", 32'(empty_a), 32'd1);
        check("midrst_full", 32'(full_a), 32'd0);
        check("midrst_rd_data", 32'(rd_data_a), 32'd0);
        check("midrst_flags", {29'd0, ferr_a, perr_a, ovr_a}, 32'd0);
        wait_clks(3 * bit_clks);
        check("midrst_no_push", 32'(count_a), 32'd0);
        send_a(8'hA5);
        drain_a("after_rst");

        // Even parity on instance b: 0x07 needs parity bit 1
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        check("par_bad_set", 32'(perr_b), 32'd1);
        check("par_bad_count", 32'(count_b), 32'd0);
        check("par_bad_no_ferr", 32'(ferr_b), 32'd0);
        clr_b = 1'b1;
        @(negedge CLOCK);
        clr_b = 1'b0;
        check("par_clr", 32'(perr_b), 32'd0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        check("par_ok_count", 32'(count_b), 32'd1);
        check("par_ok_data", 32'(rd_data_b), 32'h07);
        check("par_ok_flags", {29'd0, ferr_b, perr_b, ovr_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
